// File: rtl/egress_drain_pkg.sv
// Shared types and width helpers for the egress drain block.
// Lane word layout is {rx_port, tx_port, data}; output word layout is {tx_port, data}.
package egress_drain_pkg;

  localparam int PORT_NUB_TOTAL = 16;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

  function automatic int port_bits(input int pn);
    return $clog2(pn);
  endfunction

  function automatic int width_port(input int pn, input int dw);
    return 2 * $clog2(pn) + dw;
  endfunction

  function automatic int width_out(input int pn, input int dw);
    return $clog2(pn) + dw;
  endfunction

endpackage

// File: rtl/egress_drain_module_lane_pick.sv
// Lowest-set-bit priority encoder: one-hot grant plus binary index of the
// lowest requesting lane.
module lane_pick #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  assign grant = req & (~req + {{(N-1){1'b0}}, 1'b1});
  assign any   = |req;

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/egress_drain_module.sv
// Drains one captured sorted frame to per-port output registers, lowest lane
// first per destination, with independent per-port backpressure.
//
// state    | meaning
// ST_IDLE  | no lane was pending in the previous cycle
// ST_DRAIN | lanes were pending in the previous cycle; a drop to none fires frame_done
module egress_drain_module
  import egress_drain_pkg::*;
#(
  parameter int PORT_NUB   = PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 in_valid,
  input  logic [PORT_NUB-1:0]                                  in_lane_en,
  input  logic [PORT_NUB*width_port(PORT_NUB, DATA_WIDTH)-1:0] port_in,
  output logic                                                 in_ready,
  output logic [PORT_NUB-1:0]                                  out_valid,
  input  logic [PORT_NUB-1:0]                                  out_ready,
  output logic [PORT_NUB*width_out(PORT_NUB, DATA_WIDTH)-1:0]  port_out,
  output logic                                                 frame_done
);

  localparam int PW = port_bits(PORT_NUB);
  localparam int WP = width_port(PORT_NUB, DATA_WIDTH);
  localparam int WO = width_out(PORT_NUB, DATA_WIDTH);

  logic [PORT_NUB-1:0][WP-1:0] lane_q;
  logic [PORT_NUB-1:0]         pending_q;
  logic [PORT_NUB-1:0]         pending_d;
  logic [PORT_NUB-1:0]         clear_mask;
  logic [PORT_NUB-1:0]         grant_eff [PORT_NUB];
  logic                        accept;
  drain_state_t                state_q;
  drain_state_t                state_d;
  logic                        frame_done_d;

  assign in_ready = ~|pending_q;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (accept) begin
      lane_q <= port_in;
    end
  end

  for (genvar p = 0; p < PORT_NUB; p++) begin : g_port
    logic [PORT_NUB-1:0] match;
    logic [PORT_NUB-1:0] req;
    logic [PORT_NUB-1:0] grant;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic                slot_free;
    logic                valid_q;
    logic [WO-1:0]       word_q;

    always_comb begin
      match = '0;
      for (int i = 0; i < PORT_NUB; i++) begin
        match[i] = (lane_q[i][WP-1 -: PW] == PW'(p));
      end
    end

    assign req = pending_q & match;

    lane_pick #(.N(PORT_NUB)) u_pick (
      .req   (req),
      .grant (grant),
      .idx   (pick_idx),
      .any   (pick_any)
    );

    assign slot_free    = ~valid_q | out_ready[p];
    assign grant_eff[p] = slot_free ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        word_q  <= '0;
      end else if (slot_free) begin
        if (pick_any) begin
          word_q  <= lane_q[pick_idx][WO-1:0];
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end

    assign out_valid[p]             = valid_q;
    assign port_out[p*WO +: WO]     = word_q;
  end

  // A lane leaves the pending set when it is loaded, not when the sink takes it.
  always_comb begin
    clear_mask = '0;
    for (int p = 0; p < PORT_NUB; p++) begin
      clear_mask = clear_mask | grant_eff[p];
    end
  end

  assign pending_d = accept ? in_lane_en : (pending_q & ~clear_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (~|pending_q) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // An empty frame completes immediately after acceptance.
    if (accept && ~|in_lane_en) frame_done_d = 1'b1;
  end

endmodule

// File: tb/tb_egress_drain_module.sv
// Self-checking bench: cycle-level reference of the drain rules plus a per-port
// ordered scoreboard, directed scenarios with literal expectations, and a random phase.
module tb_egress_drain_module;

  localparam int PN = 16;
  localparam int DW = 8;
  localparam int PW = 4;
  localparam int WP = 2 * PW + DW;
  localparam int WO = PW + DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [PN-1:0]     in_lane_en = '0;
  logic [PN*WP-1:0]  port_in = '0;
  logic              in_ready;
  logic [PN-1:0]     out_valid;
  logic [PN-1:0]     out_ready = '1;
  logic [PN*WO-1:0]  port_out;
  logic              frame_done;

  int tests = 0;
  int fails = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  egress_drain_module #(.PORT_NUB(PN), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_lane_en (in_lane_en),
    .port_in    (port_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .port_out   (port_out),
    .frame_done (frame_done)
  );

  // Reference: which lanes still wait, and what each output slot holds.
  bit            m_pend [PN];
  logic [PW-1:0] m_rx   [PN];
  logic [WO-1:0] m_word [PN];
  bit            m_ov   [PN];
  logic [WO-1:0] m_po   [PN];
  bit            m_fd;
  bit            m_was;
  logic [WO-1:0] sb [PN][$];

  function automatic bit m_idle();
    for (int k = 0; k < PN; k++) if (m_pend[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [PN*WO-1:0] act, input logic [PN*WO-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    bit idle, acc, found, fd;
    bit clr [PN];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < PN; k++) begin
          m_pend[k] = 0; m_ov[k] = 0; m_po[k] = '0; m_rx[k] = '0; m_word[k] = '0;
          sb[k].delete();
        end
        m_fd = 0; m_was = 0;
      end else begin
        idle = m_idle();
        acc  = in_valid && idle;
        for (int k = 0; k < PN; k++) clr[k] = 0;
        for (int p = 0; p < PN; p++) begin
          if (!m_ov[p] || out_ready[p]) begin
            found = 0;
            for (int k = 0; k < PN; k++) begin
              if (!found && m_pend[k] && int'(m_rx[k]) == p) begin
                m_po[p] = m_word[k]; m_ov[p] = 1; clr[k] = 1; found = 1;
              end
            end
            if (!found) m_ov[p] = 0;
          end
        end
        fd = (m_was && idle) || (acc && in_lane_en == '0);
        m_was = !idle;
        if (acc) begin
          for (int k = 0; k < PN; k++) begin
            m_pend[k] = in_lane_en[k];
            m_rx[k]   = port_in[k*WP+WO +: PW];
            m_word[k] = port_in[k*WP +: WO];
          end
          for (int p = 0; p < PN; p++)
            for (int k = 0; k < PN; k++)
              if (in_lane_en[k] && int'(m_rx[k]) == p) sb[p].push_back(m_word[k]);
        end else begin
          for (int k = 0; k < PN; k++) if (clr[k]) m_pend[k] = 0;
        end
        m_fd = fd;
      end
    end
  end

  initial begin : compare
    logic [PN*WO-1:0] exp_po;
    logic [PN-1:0]    exp_ov;
    logic [WO-1:0]    got;
    forever begin
      @(negedge clk);
      for (int p = 0; p < PN; p++) begin
        exp_ov[p] = m_ov[p];
        exp_po[p*WO +: WO] = m_po[p];
      end
      check("out_valid", PN*WO'(out_valid), PN*WO'(exp_ov));
      check("port_out", port_out, exp_po);
      check("in_ready", PN*WO'(in_ready), PN*WO'(m_idle()));
      check("frame_done", PN*WO'(frame_done), PN*WO'(m_fd));
      if (rst_n) begin
        for (int p = 0; p < PN; p++) begin
          if (out_valid[p] && out_ready[p]) begin
            got = port_out[p*WO +: WO];
            if (sb[p].size() == 0) begin
              check("sb_unexpected_word", PN*WO'(got), '0);
              if (got == '0) check("sb_unexpected_word", 1, 0);
            end else begin
              check("sb_order", PN*WO'(got), PN*WO'(sb[p].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = PN'($urandom);
    end
  end

  function automatic logic [WP-1:0] mk_lane(input int rx, input int tx, input int d);
    logic [PW-1:0] r, t;
    logic [DW-1:0] dd;
    r = PW'(rx); t = PW'(tx); dd = DW'(d);
    return {r, t, dd};
  endfunction

  task automatic offer(input logic [PN-1:0] en, input logic [PN*WP-1:0] pi);
    @(posedge clk); #1;
    in_valid = 1'b1; in_lane_en = en; port_in = pi;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (in_ready && out_valid == '0 && !frame_done) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", budget);
    end
  endtask

  task automatic check_sb_empty(input string name);
    int n;
    n = 0;
    for (int p = 0; p < PN; p++) n += sb[p].size();
    check(name, PN*WO'(n), '0);
  endtask

  task automatic do_reset_checks();
    @(negedge clk);
    check("rst_out_valid", PN*WO'(out_valid), '0);
    check("rst_port_out", port_out, '0);
    check("rst_frame_done", PN*WO'(frame_done), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", PN*WO'(in_ready), PN*WO'(1));
  endtask

  initial begin : stim
    logic [PN*WP-1:0] pi;
    logic [PN*WO-1:0] exp_po;
    logic [PW-1:0]    rxs [PN];
    logic [PW-1:0]    tmp;
    logic [PN-1:0]    en;
    bit               ok;

    // 1: reset
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    do_reset_checks();

    // 2: permutation, lane i -> port 15-i
    for (int i = 0; i < PN; i++) pi[i*WP +: WP] = mk_lane(15 - i, i, 8'hA0 + i);
    offer('1, pi);
    @(negedge clk);
    check("perm_t1_valid", PN*WO'(out_valid), '0);
    @(negedge clk);
    for (int p = 0; p < PN; p++) exp_po[p*WO +: WO] = {PW'(15 - p), DW'(8'hA0 + 15 - p)};
    check("perm_t2_valid", PN*WO'(out_valid), PN*WO'(16'hFFFF));
    check("perm_t2_data", port_out, exp_po);
    check("perm_t2_fd", PN*WO'(frame_done), '0);
    @(negedge clk);
    check("perm_t3_fd", PN*WO'(frame_done), PN*WO'(1));
    wait_idle(20);

    // 3: hot spot on port 3
    for (int i = 0; i < PN; i++) pi[i*WP +: WP] = mk_lane(3, i, i);
    offer('1, pi);
    @(negedge clk);
    for (int i = 0; i < PN; i++) begin
      @(negedge clk);
      check("hot_valid", PN*WO'(out_valid), PN*WO'(16'h0008));
      check("hot_data", PN*WO'(port_out[3*WO +: WO]), PN*WO'({PW'(i), DW'(i)}));
      if (i == 14) check("hot_busy", PN*WO'(in_ready), '0);
      if (i == 15) check("hot_ready", PN*WO'(in_ready), PN*WO'(1));
    end
    @(negedge clk);
    check("hot_fd", PN*WO'(frame_done), PN*WO'(1));
    wait_idle(20);

    // 4: backpressure on port 7
    out_ready = 16'hFF7F;
    pi = '0;
    pi[4*WP +: WP] = mk_lane(7, 4, 8'h44);
    pi[5*WP +: WP] = mk_lane(7, 5, 8'h55);
    offer(16'h0030, pi);
    repeat (10) @(negedge clk);
    check("bp_hold_word", PN*WO'(port_out[7*WO +: WO]), PN*WO'({4'd4, 8'h44}));
    check("bp_hold_valid", PN*WO'(out_valid), PN*WO'(16'h0080));
    check("bp_in_ready", PN*WO'(in_ready), '0);
    @(posedge clk); #1 out_ready = '1;
    @(negedge clk);
    check("bp_rel_word4", PN*WO'(port_out[7*WO +: WO]), PN*WO'({4'd4, 8'h44}));
    @(negedge clk);
    check("bp_rel_word5", PN*WO'(port_out[7*WO +: WO]), PN*WO'({4'd5, 8'h55}));
    wait_idle(20);

    // 5: overlap, second frame held on in_valid during drain
    for (int i = 0; i < PN; i++) pi[i*WP +: WP] = mk_lane(2 + (i / 4), i, 8'h10 + i);
    offer(16'h0F0F, pi);
    for (int i = 0; i < PN; i++) pi[i*WP +: WP] = mk_lane(2, i, 8'hC0 + i);
    in_valid = 1'b1; in_lane_en = 16'h00FF; port_in = pi;
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    check("ovl_ready_seen", PN*WO'(ok), PN*WO'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle(40);
    check_sb_empty("ovl_sb_drained");

    // 6: random sorted frames with reset mid-drain
    rand_rdy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < PN; i++) rxs[i] = PW'($urandom);
      for (int a = 0; a < PN - 1; a++)
        for (int b = 0; b < PN - 1 - a; b++)
          if (rxs[b] > rxs[b+1]) begin tmp = rxs[b]; rxs[b] = rxs[b+1]; rxs[b+1] = tmp; end
      for (int i = 0; i < PN; i++) pi[i*WP +: WP] = mk_lane(int'(rxs[i]), i, int'($urandom_range(255)));
      en = PN'($urandom);
      ok = 0;
      for (int c = 0; c < 400 && !ok; c++) begin
        @(negedge clk);
        if (in_ready) ok = 1;
      end
      check("rnd_ready_seen", PN*WO'(ok), PN*WO'(1));
      offer(en, pi);
      if (f == 5) begin
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        do_reset_checks();
        check_sb_empty("rnd_sb_after_reset");
      end
    end
    @(posedge clk); #1;
    rand_rdy = 1'b0;
    out_ready = '1;
    wait_idle(200);
    check_sb_empty("rnd_sb_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
